// File: rtl/mem_stream_reader.sv
// Byte-masked write memory with a wrapping valid/ready streaming read engine.
// Optional MEM_STREAM_READER_BYPASS_EN: a same-edge write to the entry being read is forwarded (write-first).
module mem_stream_reader #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               io_wr_en,
   input  logic [AW-1:0]      io_wr_addr,
   input  logic [WIDTH-1:0]   io_wr_data,
   input  logic [WIDTH/8-1:0] io_wr_mask,
   input  logic               io_start,
   input  logic [AW-1:0]      io_base,
   input  logic [AW:0]        io_count,
   output logic               io_busy,
   output logic               io_out_valid,
   input  logic               io_out_ready,
   output logic [WIDTH-1:0]   io_out_data,
   output logic [AW-1:0]      io_out_addr,
   output logic               io_out_last
);

   localparam int NB = WIDTH / 8;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   mem [DEPTH];
   logic [AW-1:0]      ptr;
   logic [AW:0]        rem;
   logic [WIDTH-1:0]   rd_word;
   logic               start_ok;
   logic               load;
   logic               accept;
   logic               rem_is_one;

   assign start_ok   = (state == IDLE) && io_start && (io_count != '0);
   assign load       = (state == READ) && (!io_out_valid || io_out_ready);
   assign accept     = io_out_valid && io_out_ready;
   assign rem_is_one = (rem == (AW+1)'(1));
   assign io_busy    = (state != IDLE);

   // Storage is intentionally not reset; only enabled bytes are updated.
   always_ff @(posedge clk) begin
      if (io_wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (io_wr_mask[b]) begin
               mem[io_wr_addr][8*b +: 8] <= io_wr_data[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      rd_word = mem[ptr];
`ifdef MEM_STREAM_READER_BYPASS_EN
      if (io_wr_en && (io_wr_addr == ptr)) begin
         for (int b = 0; b < NB; b++) begin
            if (io_wr_mask[b]) begin
               rd_word[8*b +: 8] = io_wr_data[8*b +: 8];
            end
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok) state_nxt = READ;
         READ:    if (load && rem_is_one) state_nxt = DRAIN;
         DRAIN:   if (accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output register only reloads once the held word has been taken.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr          <= '0;
         rem          <= '0;
         io_out_valid <= 1'b0;
         io_out_last  <= 1'b0;
         io_out_data  <= '0;
         io_out_addr  <= '0;
      end else if (start_ok) begin
         ptr <= io_base;
         rem <= io_count;
      end else if (load) begin
         io_out_data  <= rd_word;
         io_out_addr  <= ptr;
         io_out_last  <= rem_is_one;
         io_out_valid <= 1'b1;
         ptr          <= ptr + 1'b1;
         rem          <= rem - 1'b1;
      end else if ((state == DRAIN) && accept) begin
         io_out_valid <= 1'b0;
         io_out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: masked-write table plus burst corner-case sequences.
module tb_mem_stream_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        io_wr_en;
   logic [2:0]  io_wr_addr;
   logic [31:0] io_wr_data;
   logic [3:0]  io_wr_mask;
   logic        io_start;
   logic [2:0]  io_base;
   logic [3:0]  io_count;
   logic        io_busy;
   logic        io_out_valid;
   logic        io_out_ready;
   logic [31:0] io_out_data;
   logic [2:0]  io_out_addr;
   logic        io_out_last;

   int total = 0;
   int bad   = 0;

   logic [31:0] cap_data [16];
   logic [2:0]  cap_addr [16];
   logic        cap_last [16];
   int          cap_n;
   int          busy_low_k;

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] data;
      logic [3:0]  mask;
      logic [31:0] exp;
   } wr_vec_t;

   wr_vec_t vecs [8];

   mem_stream_reader #(.WIDTH(32), .DEPTH(8), .AW(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .io_wr_en     (io_wr_en),
      .io_wr_addr   (io_wr_addr),
      .io_wr_data   (io_wr_data),
      .io_wr_mask   (io_wr_mask),
      .io_start     (io_start),
      .io_base      (io_base),
      .io_count     (io_count),
      .io_busy      (io_busy),
      .io_out_valid (io_out_valid),
      .io_out_ready (io_out_ready),
      .io_out_data  (io_out_data),
      .io_out_addr  (io_out_addr),
      .io_out_last  (io_out_last)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [2:0] addr, input logic [31:0] data, input logic [3:0] mask);
      io_wr_en   = 1'b1;
      io_wr_addr = addr;
      io_wr_data = data;
      io_wr_mask = mask;
      tick();
      io_wr_en   = 1'b0;
   endtask

   task automatic start_burst(input logic [2:0] base, input logic [3:0] count);
      io_start = 1'b1;
      io_base  = base;
      io_count = count;
      tick();
      io_start = 1'b0;
   endtask

   // Streams with ready held high; k counts edges after the start edge.
   task automatic run_burst(input logic [2:0] base, input logic [3:0] count);
      io_out_ready = 1'b1;
      start_burst(base, count);
      cap_n      = 0;
      busy_low_k = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (io_out_valid && cap_n < 16) begin
            cap_data[cap_n] = io_out_data;
            cap_addr[cap_n] = io_out_addr;
            cap_last[cap_n] = io_out_last;
            cap_n++;
         end
         if (!io_busy) begin
            busy_low_k = k;
            break;
         end
      end
   endtask

   initial begin
      vecs[0] = '{3'd2, 32'hFFFF_FFFF, 4'b1111, 32'hFFFF_FFFF};
      vecs[1] = '{3'd2, 32'h1234_5678, 4'b0101, 32'hFF34_FF78};
      vecs[2] = '{3'd2, 32'h0000_0000, 4'b0000, 32'hFF34_FF78};
      vecs[3] = '{3'd5, 32'hA1B2_C3D4, 4'b1111, 32'hA1B2_C3D4};
      vecs[4] = '{3'd5, 32'h0000_0000, 4'b1000, 32'h00B2_C3D4};
      vecs[5] = '{3'd5, 32'hFFFF_FFFF, 4'b0010, 32'h00B2_FFD4};
      vecs[6] = '{3'd0, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF};
      vecs[7] = '{3'd7, 32'hCAFE_F00D, 4'b1100, 32'hCAFE_0000};

      reset        = 1'b0;
      io_wr_en     = 1'b0;
      io_wr_addr   = '0;
      io_wr_data   = '0;
      io_wr_mask   = '0;
      io_start     = 1'b0;
      io_base      = '0;
      io_count     = '0;
      io_out_ready = 1'b0;
      tick();
      tick();
      check_output("reset_valid", io_out_valid, 0);
      check_output("reset_busy", io_busy, 0);
      check_output("reset_last", io_out_last, 0);
      check_output("reset_data", io_out_data, 0);
      check_output("reset_addr", io_out_addr, 0);
      reset = 1'b1;
      tick();

      // mem[7] is seeded so the partial-mask vector has a known starting value
      apply_stimulus(3'd7, 32'h0000_0000, 4'b1111);
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i].addr, vecs[i].data, vecs[i].mask);
         run_burst(vecs[i].addr, 4'd1);
         check_output($sformatf("vec%0d_count", i), cap_n, 1);
         check_output($sformatf("vec%0d_data", i), cap_data[0], vecs[i].exp);
         check_output($sformatf("vec%0d_addr", i), cap_addr[0], vecs[i].addr);
         check_output($sformatf("vec%0d_last", i), cap_last[0], 1);
      end

      // Wrap-around burst
      for (int k = 0; k < 8; k++) apply_stimulus(3'(k), 32'(k), 4'b1111);
      run_burst(3'd6, 4'd4);
      check_output("wrap_count", cap_n, 4);
      for (int j = 0; j < 4; j++) begin
         check_output($sformatf("wrap_addr%0d", j), cap_addr[j], (6 + j) % 8);
         check_output($sformatf("wrap_data%0d", j), cap_data[j], (6 + j) % 8);
         check_output($sformatf("wrap_last%0d", j), cap_last[j], (j == 3) ? 1 : 0);
      end
      check_output("wrap_busy_edges", busy_low_k, 5);

      // Full-depth burst covers every entry once
      run_burst(3'd3, 4'd8);
      check_output("full_count", cap_n, 8);
      check_output("full_addr7", cap_addr[7], 2);
      check_output("full_data4", cap_data[4], 7);
      check_output("full_last7", cap_last[7], 1);
      check_output("full_last6", cap_last[6], 0);

      // Backpressure
      io_out_ready = 1'b0;
      start_burst(3'd3, 4'd3);
      tick();
      check_output("bp_first_valid", io_out_valid, 1);
      for (int c = 0; c < 4; c++) begin
         tick();
         check_output($sformatf("bp_hold_valid%0d", c), io_out_valid, 1);
         check_output($sformatf("bp_hold_data%0d", c), io_out_data, 3);
         check_output($sformatf("bp_hold_addr%0d", c), io_out_addr, 3);
         check_output($sformatf("bp_hold_last%0d", c), io_out_last, 0);
      end
      io_out_ready = 1'b1;
      tick();
      check_output("bp_w1_data", io_out_data, 4);
      check_output("bp_w1_last", io_out_last, 0);
      tick();
      check_output("bp_w2_data", io_out_data, 5);
      check_output("bp_w2_last", io_out_last, 1);
      tick();
      check_output("bp_end_valid", io_out_valid, 0);
      check_output("bp_end_busy", io_busy, 0);

      // Ignored starts
      start_burst(3'd1, 4'd0);
      check_output("zero_count_busy", io_busy, 0);
      tick();
      check_output("zero_count_valid", io_out_valid, 0);
      io_out_ready = 1'b1;
      start_burst(3'd0, 4'd2);
      tick();
      check_output("busy_start_w0", io_out_data, 0);
      io_start = 1'b1;
      io_base  = 3'd5;
      io_count = 4'd4;
      tick();
      check_output("busy_start_w1", io_out_data, 1);
      check_output("busy_start_last", io_out_last, 1);
      io_start = 1'b0;
      tick();
      check_output("busy_start_valid", io_out_valid, 0);
      check_output("busy_start_busy", io_busy, 0);

      // Reset cutting a burst
      io_out_ready = 1'b0;
      start_burst(3'd0, 4'd4);
      tick();
      check_output("pre_reset_valid", io_out_valid, 1);
      #2;
      reset = 1'b0;
      #1;
      check_output("async_reset_valid", io_out_valid, 0);
      check_output("async_reset_busy", io_busy, 0);
      check_output("async_reset_data", io_out_data, 0);
      tick();
      reset = 1'b1;
      io_out_ready = 1'b1;
      tick();
      check_output("post_reset_valid", io_out_valid, 0);
      check_output("post_reset_busy", io_busy, 0);
      run_burst(3'd1, 4'd2);
      check_output("post_reset_count", cap_n, 2);
      check_output("post_reset_d0", cap_data[0], 1);
      check_output("post_reset_d1", cap_data[1], 2);
      check_output("post_reset_last1", cap_last[1], 1);

      // Read/write collision on the load edge
      apply_stimulus(3'd4, 32'hAAAA_AAAA, 4'b1111);
      io_out_ready = 1'b1;
      start_burst(3'd4, 4'd1);
      io_wr_en   = 1'b1;
      io_wr_addr = 3'd4;
      io_wr_data = 32'h5555_5555;
      io_wr_mask = 4'b0011;
      tick();
      io_wr_en = 1'b0;
`ifdef MEM_STREAM_READER_BYPASS_EN
      check_output("collision_data", io_out_data, 32'hAAAA_5555);
`else
      check_output("collision_data", io_out_data, 32'hAAAA_AAAA);
`endif
      check_output("collision_addr", io_out_addr, 4);
      check_output("collision_last", io_out_last, 1);
      tick();
      check_output("collision_busy", io_busy, 0);
      run_burst(3'd4, 4'd1);
      check_output("collision_mem", cap_data[0], 32'hAAAA_5555);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
